// File: rtl/gridworld_monitor.sv
// Gridworld agent stepper with online task monitor and sticky verdict.
// Define GW_WRAP_EN for toroidal edges; default build saturates at 0/MAX.
module gridworld_monitor #(
    parameter int COORD_W = 3,
    parameter int HORIZON = 48,
    parameter int CNT_W   = $clog2(HORIZON + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [2:0]         act,
    input  logic               act_valid,
    output logic               act_ready,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [3:0]         colors,
    output logic [CNT_W-1:0]   step_cnt,
    output logic               done,
    output logic [1:0]         verdict
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] V_RUN  = 2'd0;
    localparam logic [1:0] V_SAT  = 2'd1;
    localparam logic [1:0] V_VIOL = 2'd2;

    localparam logic [COORD_W-1:0] ZERO_C = '0;
    localparam logic [COORD_W-1:0] ONE_C  = COORD_W'(1);
    localparam logic [COORD_W-1:0] TWO_C  = COORD_W'(2);
    localparam logic [COORD_W-1:0] MAX_C  = '1;
    localparam logic [COORD_W-1:0] MAXM1  = MAX_C - ONE_C;
    localparam logic [COORD_W-1:0] MAXM2  = MAX_C - TWO_C;
    localparam logic [COORD_W-1:0] H_C    = {1'b1, {(COORD_W-1){1'b0}}};
    localparam logic [COORD_W-1:0] HM1    = H_C - ONE_C;
    localparam logic [COORD_W-1:0] HP1    = H_C + ONE_C;
    localparam logic [CNT_W-1:0]   HOR_C  = CNT_W'(HORIZON);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] px_q, px_d;
    logic [COORD_W-1:0] py_q, py_d;
    logic [3:0]         col_q, col_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bs_q, bs_d;
    logic [1:0]         verd_q, verd_d;

    logic               x_inc, x_dec, y_inc, y_dec;
    logic [COORD_W-1:0] nx, ny;
    logic [3:0]         ncol;
    logic [CNT_W-1:0]   ncnt;
    logic [1:0]         nverd;
    logic               nbs;

    // Region sensing: returns {blue, yellow, brown, red} for a cell.
    function automatic logic [3:0] sense(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y
    );
        logic x_edge, y_edge, x_in, y_in, x_mid, y_band;
        logic yel, brn, blu, red;
        x_edge = (x == ZERO_C) || (x == MAX_C);
        y_edge = (y == ZERO_C) || (y == MAX_C);
        x_in   = (x >= TWO_C) && (x <= MAXM2);
        y_in   = (y >= TWO_C) && (y <= MAXM2);
        x_mid  = (x == HM1) || (x == H_C);
        y_band = (y == H_C) || (y == HP1);
        yel    = x_edge && y_edge;
        brn    = x_in && y_edge;
        blu    = x_mid && y_in;
        red    = (((x == ONE_C) || (x == MAXM1)) &&
                  ((y <= ONE_C) || y_band)) ||
                 (x_edge && ((y == ONE_C) || y_band));
        return {blu, yel, brn, red};
    endfunction

    // One axis of motion; edge handling selected at build time.
    function automatic logic [COORD_W-1:0] step_axis(
        input logic [COORD_W-1:0] v,
        input logic               inc,
        input logic               dec
    );
        logic [COORD_W-1:0] r;
        r = v;
`ifdef GW_WRAP_EN
        if (inc) r = v + ONE_C;
        else if (dec) r = v - ONE_C;
`else
        if (inc && (v != MAX_C)) r = v + ONE_C;
        else if (dec && (v != ZERO_C)) r = v - ONE_C;
`endif
        return r;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            px_q    <= '0;
            py_q    <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            bs_q    <= 1'b0;
            verd_q  <= V_RUN;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            bs_q    <= bs_d;
            verd_q  <= verd_d;
        end
    end

    // Candidate step: decode, move, sense and evaluate the monitor.
    always_comb begin
        x_inc = 1'b0;
        x_dec = 1'b0;
        y_inc = 1'b0;
        y_dec = 1'b0;
        unique case (act)
            3'd0: y_inc = 1'b1;
            3'd1: begin x_inc = 1'b1; y_inc = 1'b1; end
            3'd2: x_inc = 1'b1;
            3'd3: begin x_inc = 1'b1; y_dec = 1'b1; end
            3'd4: y_dec = 1'b1;
            3'd5: begin x_dec = 1'b1; y_dec = 1'b1; end
            3'd6: x_dec = 1'b1;
            3'd7: begin x_dec = 1'b1; y_inc = 1'b1; end
            default: ;
        endcase
        nx    = step_axis(px_q, x_inc, x_dec);
        ny    = step_axis(py_q, y_inc, y_dec);
        ncol  = sense(nx, ny);
        ncnt  = cnt_q + CNT_W'(1);
        nverd = V_RUN;
        nbs   = bs_q;
        if (ncol[0]) begin
            nverd = V_VIOL;
        end else if (ncol[1] && !bs_q) begin
            nverd = V_VIOL;
        end else if (ncol[1]) begin
            nverd = V_SAT;
        end else if (ncol[3]) begin
            nbs = 1'b1;
        end
        // Running out of steps without a decision is a failure.
        if ((nverd == V_RUN) && (ncnt == HOR_C)) begin
            nverd = V_VIOL;
        end
    end

    // Next-state selection: start wins over any same-cycle handshake.
    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        bs_d    = bs_q;
        verd_d  = verd_q;
        if (start) begin
            state_d = S_RUN;
            px_d    = x0;
            py_d    = y0;
            col_d   = sense(x0, y0);
            cnt_d   = '0;
            bs_d    = 1'b0;
            verd_d  = V_RUN;
        end else if ((state_q == S_RUN) && act_valid) begin
            px_d   = nx;
            py_d   = ny;
            col_d  = ncol;
            cnt_d  = ncnt;
            bs_d   = nbs;
            verd_d = nverd;
            if (nverd != V_RUN) begin
                state_d = S_DONE;
            end
        end
    end

    // Outputs are pure functions of the registered state.
    always_comb begin
        act_ready = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        pos_x     = px_q;
        pos_y     = py_q;
        colors    = col_q;
        step_cnt  = cnt_q;
        verdict   = verd_q;
    end

endmodule

// File: tb/tb_gridworld_monitor.sv
// Randomized and directed bench for gridworld_monitor against a
// behavioural model; runs a default-horizon and a HORIZON=4 instance.
module tb_gridworld_monitor;

    localparam int MAXV = 7;
    localparam int HV   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] x0, y0, act;
    logic       act_valid;

    logic       a_ready, a_done;
    logic [2:0] a_x, a_y;
    logic [3:0] a_col;
    logic [5:0] a_cnt;
    logic [1:0] a_verd;

    logic       b_ready, b_done;
    logic [2:0] b_x, b_y;
    logic [3:0] b_col;
    logic [2:0] b_cnt;
    logic [1:0] b_verd;

    gridworld_monitor #(.COORD_W(3), .HORIZON(48)) dut_a (
        .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0),
        .act(act), .act_valid(act_valid), .act_ready(a_ready),
        .pos_x(a_x), .pos_y(a_y), .colors(a_col),
        .step_cnt(a_cnt), .done(a_done), .verdict(a_verd)
    );

    gridworld_monitor #(.COORD_W(3), .HORIZON(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0),
        .act(act), .act_valid(act_valid), .act_ready(b_ready),
        .pos_x(b_x), .pos_y(b_y), .colors(b_col),
        .step_cnt(b_cnt), .done(b_done), .verdict(b_verd)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Model state: index 0 = HORIZON 48, index 1 = HORIZON 4.
    // st: 0 idle, 1 run, 2 done. v: 0 running, 1 sat, 2 viol.
    int m_x[2], m_y[2], m_col[2], m_cnt[2], m_bs[2], m_v[2], m_st[2];
    int m_hz[2] = '{48, 4};
    int DX[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int DY[8] = '{1, 1, 0, -1, -1, -1, 0, 1};

    function automatic int col_of(int x, int y);
        bit ecol, erow, band, yel, brn, blu, red;
        ecol = (x == 0) || (x == MAXV);
        erow = (y == 0) || (y == MAXV);
        band = (y == HV) || (y == HV + 1);
        yel  = ecol && erow;
        brn  = (x >= 2) && (x <= MAXV - 2) && erow;
        blu  = (x == HV - 1 || x == HV) && (y >= 2) && (y <= MAXV - 2);
        red  = ((x == 1 || x == MAXV - 1) && (y <= 1 || band)) ||
               (ecol && (y == 1 || band));
        return 8 * int'(blu) + 4 * int'(yel) + 2 * int'(brn) + int'(red);
    endfunction

    function automatic int move(int p, int d);
        int r;
        r = p + d;
`ifdef GW_WRAP_EN
        r = (r + MAXV + 1) % (MAXV + 1);
`else
        if (r < 0) r = 0;
        if (r > MAXV) r = MAXV;
`endif
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_x[k] = 0; m_y[k] = 0; m_col[k] = 0; m_cnt[k] = 0;
            m_bs[k] = 0; m_v[k] = 0; m_st[k] = 0;
        end
    endtask

    task automatic model_edge(int s, int xs, int ys, int a, int v);
        int c;
        for (int k = 0; k < 2; k++) begin
            if (s != 0) begin
                m_st[k] = 1; m_x[k] = xs; m_y[k] = ys;
                m_col[k] = col_of(xs, ys);
                m_cnt[k] = 0; m_bs[k] = 0; m_v[k] = 0;
            end else if (m_st[k] == 1 && v != 0) begin
                m_x[k] = move(m_x[k], DX[a]);
                m_y[k] = move(m_y[k], DY[a]);
                c = col_of(m_x[k], m_y[k]);
                m_col[k] = c;
                m_cnt[k]++;
                if (c[0]) m_v[k] = 2;
                else if (c[1] && m_bs[k] == 0) m_v[k] = 2;
                else if (c[1]) m_v[k] = 1;
                else if (c[3]) m_bs[k] = 1;
                if (m_v[k] == 0 && m_cnt[k] == m_hz[k]) m_v[k] = 2;
                if (m_v[k] != 0) m_st[k] = 2;
            end
        end
    endtask

    task automatic check_all(input string t);
        check({t, ":a_x"}, 32'(a_x), m_x[0]);
        check({t, ":a_y"}, 32'(a_y), m_y[0]);
        check({t, ":a_col"}, 32'(a_col), m_col[0]);
        check({t, ":a_cnt"}, 32'(a_cnt), m_cnt[0]);
        check({t, ":a_verd"}, 32'(a_verd), m_v[0]);
        check({t, ":a_done"}, 32'(a_done), 32'(m_st[0] == 2));
        check({t, ":a_rdy"}, 32'(a_ready), 32'(m_st[0] == 1));
        check({t, ":b_x"}, 32'(b_x), m_x[1]);
        check({t, ":b_y"}, 32'(b_y), m_y[1]);
        check({t, ":b_col"}, 32'(b_col), m_col[1]);
        check({t, ":b_cnt"}, 32'(b_cnt), m_cnt[1]);
        check({t, ":b_verd"}, 32'(b_verd), m_v[1]);
        check({t, ":b_done"}, 32'(b_done), 32'(m_st[1] == 2));
        check({t, ":b_rdy"}, 32'(b_ready), 32'(m_st[1] == 1));
    endtask

    task automatic cycle(input string t, int s, int xs, int ys,
                         int a, int v);
        @(negedge clk);
        start = 1'(s); x0 = 3'(xs); y0 = 3'(ys);
        act = 3'(a); act_valid = 1'(v);
        @(posedge clk);
        model_edge(s, xs, ys, a, v);
        #1;
        check_all(t);
    endtask

    task automatic async_reset(input string t);
        @(negedge clk);
        start = 1'b0; act_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(t);
        @(negedge clk);
        rst = 1'b0;
        act_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; x0 = '0; y0 = '0;
        act = '0; act_valid = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        cycle("idle_valid", 0, 0, 0, 2, 1);

        // Blue then brown: satisfied.
        cycle("t1_start", 1, 3, 0, 0, 0);
        cycle("t1_s1", 0, 0, 0, 0, 1);
        check("t1_blue_pos", 32'(a_y), 1);
        cycle("t1_s2", 0, 0, 0, 0, 1);
        check("t1_blue_col", 32'(a_col), 8);
        cycle("t1_s3", 0, 0, 0, 4, 1);
        cycle("t1_s4", 0, 0, 0, 4, 1);
        check("t1_verdict", 32'(a_verd), 1);
        check("t1_done", 32'(a_done), 1);
        check("t1_cnt", 32'(a_cnt), 4);
        check("t1_ready", 32'(a_ready), 0);

        // Brown without blue.
        cycle("t2_start", 1, 3, 0, 0, 0);
        cycle("t2_s1", 0, 0, 0, 6, 1);
        check("t2_verdict", 32'(a_verd), 2);
        check("t2_cnt", 32'(a_cnt), 1);

        // Red cell, then ignored action in DONE.
        cycle("t3_start", 1, 3, 0, 0, 0);
        cycle("t3_s1", 0, 0, 0, 0, 1);
        cycle("t3_s2", 0, 0, 0, 6, 1);
        cycle("t3_s3", 0, 0, 0, 6, 1);
        check("t3_verdict", 32'(a_verd), 2);
        check("t3_cnt", 32'(a_cnt), 3);
        cycle("t3_hold", 0, 0, 0, 0, 1);
        check("t3_hold_x", 32'(a_x), 1);
        check("t3_hold_y", 32'(a_y), 1);

        // Right edge.
        cycle("t4_start", 1, 7, 3, 0, 0);
        cycle("t4_s1", 0, 0, 0, 2, 1);
`ifdef GW_WRAP_EN
        check("t4_x", 32'(a_x), 0);
`else
        check("t4_x", 32'(a_x), 7);
`endif
        check("t4_col", 32'(a_col), 0);
        check("t4_cnt", 32'(a_cnt), 1);
        check("t4_verd", 32'(a_verd), 0);

        // Horizon expiry on the short instance.
        cycle("t5_start", 1, 6, 2, 0, 0);
        cycle("t5_s1", 0, 0, 0, 2, 1);
        cycle("t5_s2", 0, 0, 0, 6, 1);
        cycle("t5_s3", 0, 0, 0, 2, 1);
        cycle("t5_s4", 0, 0, 0, 6, 1);
        check("t5_b_verd", 32'(b_verd), 2);
        check("t5_b_done", 32'(b_done), 1);
        check("t5_b_cnt", 32'(b_cnt), 4);
        check("t5_a_verd", 32'(a_verd), 0);

        // Asynchronous reset mid-episode, then start + dropped action.
        cycle("t6_start", 1, 3, 0, 0, 0);
        cycle("t6_s1", 0, 0, 0, 0, 1);
        cycle("t6_s2", 0, 0, 0, 0, 1);
        async_reset("t6_arst");
        check("t6_arst_y", 32'(a_y), 0);
        cycle("t6_restart", 1, 3, 0, 0, 1);
        check("t6_drop_cnt", 32'(a_cnt), 0);
        check("t6_drop_y", 32'(a_y), 0);
        cycle("t6_viol", 0, 0, 0, 6, 1);
        cycle("t6_done_start", 1, 5, 5, 0, 0);
        check("t6_rerun_rdy", 32'(a_ready), 1);
        check("t6_rerun_verd", 32'(a_verd), 0);

        // Random episodes.
        for (int i = 0; i < 3000; i++) begin
            int s;
            if ($urandom_range(299) == 0) begin
                async_reset("rnd_arst");
            end else begin
                if (m_st[0] != 1 && m_st[1] != 1)
                    s = int'($urandom_range(3) == 0);
                else
                    s = int'($urandom_range(39) == 0);
                cycle("rnd", s, $urandom_range(7), $urandom_range(7),
                      $urandom_range(7), int'($urandom_range(9) < 7));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
